// File: rtl/branch_target_predictor.sv
// Tagged branch target predictor: same-cycle lookup for fetch, training and
// mispredict detection from execute, with a post-mispredict suppression window.
module branch_target_predictor #(
    parameter int PC_W     = 16,
    parameter int IDX_W    = 6,
    parameter int CTR_W    = 2,
    parameter int SUPPRESS = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             CPU_RESET_n,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [PC_W-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic             suppress_active,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));
    localparam logic [3:0]       SUP_LOAD = 4'(SUPPRESS);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];
    logic [CTR_W-1:0] ctr_q    [DEPTH];

    logic [3:0]       suppress_q, suppress_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;

    assign lk_idx = lookup_pc[IDX_W-1:0];
    assign lk_tag = lookup_pc[PC_W-1:IDX_W];
    assign up_idx = upd_pc[IDX_W-1:0];
    assign up_tag = upd_pc[PC_W-1:IDX_W];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign suppress_active  = (suppress_q != 4'd0);
    assign pred_taken       = lk_hit && ctr_q[lk_idx][CTR_W-1] && !suppress_active;
    assign pred_target      = pred_taken ? target_q[lk_idx] : lookup_pc + PC_W'(1);
    assign mispredict       = mispredict_q;
    assign mispredict_count = count_q;

    always_comb begin
        valid_d      = valid_q;
        mispredict_d = 1'b0;
        count_d      = count_q;
        suppress_d   = suppress_q;
        if (upd_valid && upd_taken && !up_hit) begin
            valid_d[up_idx] = 1'b1;
        end
        if (upd_valid) begin
            mispredict_d = (upd_taken != upd_pred_taken) ||
                           (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
        end
        if (mispredict_d) begin
            suppress_d = SUP_LOAD;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (suppress_q != 4'd0) begin
            suppress_d = suppress_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge CPU_RESET_n) begin
        if (!CPU_RESET_n) begin
            valid_q      <= '0;
            suppress_q   <= 4'd0;
            mispredict_q <= 1'b0;
            count_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            suppress_q   <= suppress_d;
            mispredict_q <= mispredict_d;
            count_q      <= count_d;
        end
    end

    // Payload arrays are left unreset; any write made while in reset is hidden by valid.
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
                    end
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_INIT;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed + randomized bench for branch_target_predictor against a table-level
// reference model (64 entries, 2-bit counters, suppress window 2).
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        CPU_RESET_n;
    logic [15:0] lookup_pc;
    logic        pred_taken, pred_taken2;
    logic [15:0] pred_target, pred_target2;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;
    logic        mispredict, mispredict2;
    logic        suppress_active, suppress_active2;
    logic [15:0] mispredict_count;
    logic [1:0]  mispredict_count2;

    always #5 clk = ~clk;

    branch_target_predictor dut (
        .clk(clk), .CPU_RESET_n(CPU_RESET_n), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .suppress_active(suppress_active), .mispredict_count(mispredict_count)
    );

    branch_target_predictor #(.CNT_W(2)) dut2 (
        .clk(clk), .CPU_RESET_n(CPU_RESET_n), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken2), .pred_target(pred_target2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict2),
        .suppress_active(suppress_active2), .mispredict_count(mispredict_count2)
    );

    // Reference model state
    bit m_valid [64];
    int m_tag   [64];
    int m_tgt   [64];
    int m_ctr   [64];
    int m_susp, m_cnt, m_cnt2;
    bit m_misp;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (m_valid[i]) m_valid[i] = 0;
        m_susp = 0; m_misp = 0; m_cnt = 0; m_cnt2 = 0;
    endfunction

    function automatic void model_lookup(input int pc, output bit tk, output int tg);
        int i = pc % 64;
        bit hit = m_valid[i] && (m_tag[i] == pc / 64);
        tk = hit && (m_ctr[i] >= 2) && (m_susp == 0);
        tg = tk ? m_tgt[i] : (pc + 1) % 65536;
    endfunction

    function automatic void model_edge();
        int i   = upd_pc % 64;
        int t   = upd_pc / 64;
        bit hit = m_valid[i] && (m_tag[i] == t);
        bit mp  = upd_valid && ((upd_taken != upd_pred_taken) ||
                  (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
        if (upd_valid) begin
            if (hit && upd_taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = upd_target;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end else if (upd_taken) begin
                m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = upd_target; m_ctr[i] = 2;
            end
        end
        if (mp) begin
            m_susp = 2;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else if (m_susp > 0) begin
            m_susp--;
        end
        m_misp = mp;
    endfunction

    task automatic check_all();
        bit exp_tk;
        int exp_tg;
        model_lookup(lookup_pc, exp_tk, exp_tg);
        chk("pred_taken", pred_taken, exp_tk);
        chk("pred_target", pred_target, exp_tg);
        chk("mispredict", mispredict, m_misp);
        chk("suppress_active", suppress_active, m_susp != 0);
        chk("mispredict_count", mispredict_count, m_cnt);
        chk("pred_taken_cnt2", pred_taken2, exp_tk);
        chk("mispredict_count_cnt2", mispredict_count2, m_cnt2);
    endtask

    task automatic cyc(input bit uv, input logic [15:0] upc, input bit ut,
                       input logic [15:0] utgt, input bit upt,
                       input logic [15:0] uptgt, input logic [15:0] lpc);
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_pred_taken = upt; upd_pred_target = uptgt; lookup_pc = lpc;
        #1;
        check_all();
        @(posedge clk);
        if (CPU_RESET_n) model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input logic [15:0] lpc);
        cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, lpc);
    endtask

    task automatic expect_pred(input string tag, input logic [15:0] lpc,
                               input bit tk, input logic [15:0] tg);
        upd_valid = 0; lookup_pc = lpc;
        #1;
        chk({tag, "_taken"}, pred_taken, tk);
        chk({tag, "_target"}, pred_target, tg);
    endtask

    initial begin
        CPU_RESET_n = 0; lookup_pc = 16'h0010;
        upd_valid = 1; upd_pc = 16'h0010; upd_taken = 1; upd_target = 16'h1234;
        upd_pred_taken = 0; upd_pred_target = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_target", pred_target, 16'h0011);
        chk("rst_count", mispredict_count, 0);
        chk("rst_suppress", suppress_active, 0);
        CPU_RESET_n = 1;
        idle(16'h0010);
        expect_pred("post_rst", 16'h0010, 0, 16'h0011);

        // Allocate on a taken miss
        cyc(1, 16'h0005, 1, 16'h0020, 0, 16'h0000, 16'h0005);
        chk("alloc_misp", mispredict, 1);
        chk("alloc_count", mispredict_count, 1);
        chk("alloc_susp1", suppress_active, 1);
        idle(16'h0005);
        chk("alloc_susp2", suppress_active, 1);
        idle(16'h0005);
        chk("alloc_susp_end", suppress_active, 0);
        expect_pred("alloc_hit", 16'h0005, 1, 16'h0020);
        expect_pred("tag_miss", 16'h0045, 0, 16'h0046);
        idle(16'h0045);

        // Hysteresis: saturate then two not-taken
        repeat (3) cyc(1, 16'h0005, 1, 16'h0020, 1, 16'h0020, 16'h0005);
        chk("sat_no_misp", mispredict_count, 1);
        cyc(1, 16'h0005, 0, 16'h0000, 1, 16'h0020, 16'h0005);
        repeat (3) idle(16'h0005);
        expect_pred("nt1_still_taken", 16'h0005, 1, 16'h0020);
        cyc(1, 16'h0005, 0, 16'h0000, 1, 16'h0020, 16'h0005);
        repeat (3) idle(16'h0005);
        expect_pred("nt2_not_taken", 16'h0005, 0, 16'h0006);

        // Direction mispredict then target mispredict inside the window
        cyc(1, 16'h0005, 1, 16'h0020, 0, 16'h0000, 16'h0005);
        idle(16'h0005);
        cyc(1, 16'h0005, 1, 16'h0030, 1, 16'h0020, 16'h0005);
        chk("tgt_misp", mispredict, 1);
        chk("tgt_reload", suppress_active, 1);
        idle(16'h0005);
        chk("tgt_reload2", suppress_active, 1);
        idle(16'h0005);
        expect_pred("tgt_updated", 16'h0005, 1, 16'h0030);

        expect_pred("wrap", 16'hFFFF, 0, 16'h0000);
        idle(16'hFFFF);

        for (int k = 0; k < 5; k++)
            cyc(1, 16'(16'h0100 + k), 1, 16'h0777, 0, 16'h0000, 16'h0100);
        idle(16'h0100);
        chk("cnt2_saturated", mispredict_count2, 3);

        // Mid-run reset with an update in flight
        upd_valid = 1; upd_pc = 16'h0009; upd_taken = 1; upd_target = 16'h0abc;
        upd_pred_taken = 0; lookup_pc = 16'h0005;
        #2;
        CPU_RESET_n = 0;
        model_reset();
        #1;
        check_all();
        chk("midrst_count", mispredict_count, 0);
        @(posedge clk);
        @(negedge clk);
        CPU_RESET_n = 1;
        expect_pred("midrst_dropped", 16'h0009, 0, 16'h000a);
        idle(16'h0009);

        for (int n = 0; n < 600; n++) begin
            logic [15:0] upc, lpc, utgt, ptgt;
            bit uv, ut, pt;
            upc  = 16'((($urandom % 4) * 64) + ($urandom % 4));
            lpc  = ($urandom % 8 == 0) ? 16'($urandom) :
                   16'((($urandom % 4) * 64) + ($urandom % 4));
            utgt = 16'($urandom % 4);
            ptgt = ($urandom % 2 == 0) ? utgt : 16'($urandom % 4);
            uv   = ($urandom % 4) != 0;
            ut   = ($urandom % 2) != 0;
            pt   = ($urandom % 2) != 0;
            cyc(uv, upc, ut, utgt, pt, ptgt, lpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
